// File: rtl/sum_accumulator.sv
// Frame accumulator: sums N_SAMPLES 9-bit {carry,sum} beats into an ACC_W-bit total.
// Optional macro ACC_SATURATE_EN clamps the total at all-ones on overflow instead of wrapping.
module sum_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // ACC   | summing beats 2..N_SAMPLES
  // DONE  | holding the frame result until out_ready
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0] N_CNT = 8'(N_SAMPLES);

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [7:0]       w_cnt_inc;
  logic [ACC_W-1:0] w_beat_ext;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_add;

  assign w_beat_ext = {{(ACC_W-9){1'b0}}, in_carry, in_sum};
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_beat_ext};
  assign w_cnt_inc  = r_cnt + 8'd1;

`ifdef ACC_SATURATE_EN
  // Once clamped, any further add either carries again or adds zero, so the clamp holds.
  assign w_acc_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = (N_SAMPLES == 1) ? DONE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (w_cnt_inc == N_CNT)) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        if (r_state == IDLE) begin
          r_acc <= w_beat_ext;
          r_cnt <= 8'd1;
          r_ovf <= 1'b0;
        end else begin
          r_acc <= w_acc_add;
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_sum[ACC_W];
        end
      end
    end
  end

  assign out_acc = r_acc;
  assign out_ovf = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: three instances (N4/W16, N4/W9, N1/W16) share one stimulus bus.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_sum = 8'h00;
  logic        in_carry = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_acc;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [8:0]  b_out_acc;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [15:0] c_out_acc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_acc(a_out_acc), .out_ovf(a_out_ovf));

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(9)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf));

  sum_accumulator #(.N_SAMPLES(1), .ACC_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_acc(c_out_acc), .out_ovf(c_out_ovf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] beat);
    in_valid = v;
    {in_carry, in_sum} = beat;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(1'b0, 9'h000); out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    n_vec++; if (a_out_acc !== 16'h0000) begin n_err++; $display("FAIL reset_out_acc got %h want 0000", a_out_acc); end
    n_vec++; if (a_out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got %b want 0", a_out_ovf); end
  endtask

  task automatic test_basic();
    logic [8:0] beats [4];
    beats[0] = 9'h0FF; beats[1] = 9'h100; beats[2] = 9'h1FF; beats[3] = 9'h001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid beat %0d got %b want 0", i, a_out_valid); end
      drive(1'b1, beats[i]);
      step();
    end
    drive(1'b0, 9'h000);
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got %b want 1", a_out_valid); end
    n_vec++; if (a_out_acc !== 16'h03FF) begin n_err++; $display("FAIL basic_out_acc got %h want 03ff", a_out_acc); end
    n_vec++; if (a_out_ovf !== 1'b0) begin n_err++; $display("FAIL basic_out_ovf got %b want 0", a_out_ovf); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done got %b want 0", a_in_ready); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_return_idle got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 9'h1FF); step(); end
    drive(1'b0, 9'h000);
    n_vec++; if (b_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_out_valid got %b want 1", b_out_valid); end
`ifdef ACC_SATURATE_EN
    n_vec++; if (b_out_acc !== 9'h1FF) begin n_err++; $display("FAIL ovf_out_acc_sat got %h want 1ff", b_out_acc); end
`else
    n_vec++; if (b_out_acc !== 9'h1FC) begin n_err++; $display("FAIL ovf_out_acc_wrap got %h want 1fc", b_out_acc); end
`endif
    n_vec++; if (b_out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", b_out_ovf); end
    n_vec++; if (a_out_acc !== 16'h07FC || a_out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_wide_no_ovf got %h/%b want 07fc/0", a_out_acc, a_out_ovf); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 9'h010); step(); end
    drive(1'b1, 9'h0AA);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_hs cyc %0d got ready=%b valid=%b want 0/1", i, a_in_ready, a_out_valid); end
      n_vec++; if (a_out_acc !== 16'h0040 || a_out_ovf !== 1'b0) begin n_err++; $display("FAIL bp_hold_data cyc %0d got %h/%b want 0040/0", i, a_out_acc, a_out_ovf); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(1'b0, 9'h000);
    n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready); end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 9'h001); step(); end
    drive(1'b0, 9'h000);
    n_vec++; if (a_out_valid !== 1'b1 || a_out_acc !== 16'h0004) begin n_err++; $display("FAIL bp_next_frame got valid=%b acc=%h want 1/0004", a_out_valid, a_out_acc); end
  endtask

  task automatic test_gapped();
    logic       pat [7];
    logic [8:0] val;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
    val = 9'd0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid step %0d got %b want 0", i, a_out_valid); end
      if (pat[i]) begin val = val + 9'd1; drive(1'b1, val); end
      else drive(1'b0, 9'h1EE);
      step();
    end
    drive(1'b0, 9'h000);
    n_vec++; if (a_out_valid !== 1'b1 || a_out_acc !== 16'd10) begin n_err++; $display("FAIL gap_result got valid=%b acc=%0d want 1/10", a_out_valid, a_out_acc); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive(1'b1, 9'h010); step();
    drive(1'b1, 9'h020); step();
    rst = 1'b1; drive(1'b1, 9'h005);
    step();
    rst = 1'b0; drive(1'b0, 9'h000);
    n_vec++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_acc !== 16'h0000) begin n_err++; $display("FAIL midrst_state got ready=%b valid=%b acc=%h want 1/0/0000", a_in_ready, a_out_valid, a_out_acc); end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 9'h001); step(); end
    drive(1'b0, 9'h000);
    n_vec++; if (a_out_valid !== 1'b1 || a_out_acc !== 16'h0004 || a_out_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_result got valid=%b acc=%h ovf=%b want 1/0004/0", a_out_valid, a_out_acc, a_out_ovf); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 9'h155); step();
    drive(1'b0, 9'h000);
    n_vec++; if (c_out_valid !== 1'b1 || c_in_ready !== 1'b0) begin n_err++; $display("FAIL single_hs got valid=%b ready=%b want 1/0", c_out_valid, c_in_ready); end
    n_vec++; if (c_out_acc !== 16'h0155 || c_out_ovf !== 1'b0) begin n_err++; $display("FAIL single_data got %h/%b want 0155/0", c_out_acc, c_out_ovf); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n_vec++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin n_err++; $display("FAIL single_release got valid=%b ready=%b want 0/1", c_out_valid, c_in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gapped();
    test_reset_midframe();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
